// File: rtl/spram_responder.sv
// spram_responder: responder end of the single-port RAM bus.
// The array holds DEPTH words of DATA_WIDTH bits. After reset, a sequencer writes INIT_VALUE to
// every word. While it runs, busy is high and incoming requests are dropped. After that, the
// block serves one write or one read per cycle. Read data is registered, so it appears one
// cycle after the request.
//
// Ports:
//   clk        - single clock, all logic on posedge
//   reset      - asynchronous, active-high reset
//   write_enb  - write request
//   read_enb   - read request
//   address    - word address of the current request
//   data_in    - write data
//   data_out   - registered read data; holds its value when there is no read
//   data_valid - one-cycle strobe: data_out was loaded by a read on the last edge
//   busy       - high during reset and while the clear sequence runs
//   collision  - one-cycle pulse: both enables were high on an accepted edge
//   req_drop   - one-cycle pulse: a request arrived while busy
module spram_responder #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter int unsigned           DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  collision,
  output logic                  req_drop
);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  collision_q, collision_d;
  logic                  req_drop_q, req_drop_d;

  // Storage has no reset; the clear sequencer initialises it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    busy_d       = busy_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    collision_d  = 1'b0;
    req_drop_d   = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = address;
    mem_wdata    = data_in;

    case (state_q)
      StClear: begin
        // Clock edges that arrive while reset is held write INIT_VALUE to word 0. This is
        // harmless because the sequence restarts there after reset is released.
        mem_we     = 1'b1;
        mem_waddr  = clr_cnt_q;
        mem_wdata  = INIT_VALUE;
        req_drop_d = write_enb | read_enb;
        clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LastAddr) begin
          busy_d  = 1'b0;
          state_d = StReady;
        end
      end
      StReady: begin
        // On a collision, the write is performed and the read is discarded.
        mem_we      = write_enb;
        collision_d = write_enb & read_enb;
        if (read_enb && !write_enb) begin
          data_out_d   = mem_q[address];
          data_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StClear;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      collision_q  <= 1'b0;
      req_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      collision_q  <= collision_d;
      req_drop_q   <= req_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign collision  = collision_q;
  assign req_drop   = req_drop_q;

endmodule

// File: doc/spram_responder.md
Name: spram_responder

Overview:
- Responder end of the team's single-port RAM bus: 32 x 8 storage that services write/read requests issued by the bus driver on write_enb/read_enb/address/data_in, and returns read data on data_out.
- Adds a post-reset clear sequencer, a read-valid strobe, and collision/drop flags so the monitor and scoreboard can check every access cycle-accurately.
- Sits directly behind the RAM interface as the DUT memory.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out and each memory word
- ADDR_WIDTH, 5, width of address
- DEPTH, 32, number of words; must equal 2**ADDR_WIDTH
- INIT_VALUE, 8'h00, value written to every location by the clear sequencer

Ports:
- clk  input  1  single clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- write_enb  input  1  write request, sampled on posedge clk
- read_enb  input  1  read request, sampled on posedge clk
- address  input  ADDR_WIDTH  word address for the current request
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data
- data_valid  output  1  one-cycle strobe: data_out carries data from a read accepted on this edge
- busy  output  1  high while reset is asserted or the clear sequence is running; requests are not accepted
- collision  output  1  one-cycle pulse: write_enb and read_enb were both high on an accepted edge
- req_drop  output  1  one-cycle pulse: a request arrived while busy

Behaviour:
- Reset asserted (async, immediate):
  - data_out=0, data_valid=0, collision=0, req_drop=0, busy=1.
  - State=CLEAR, clear counter=0.
  - The memory array is not reset directly; the sequencer initialises it.
- State machine: CLEAR -> READY.
  - CLEAR: on each posedge after reset deasserts, mem[clr_cnt] <= INIT_VALUE and clr_cnt increments.
  - On the edge that writes address DEPTH-1, busy is registered to 0 and the state moves to READY.
  - With reset released before edge 1: edges 1..32 clear addresses 0..31, busy falls at edge 32, and the first request is accepted at edge 33.
  - READY is held until the next reset.
- Reset asserted during CLEAR or READY: immediate return to reset values; the clear restarts from address 0 once reset is released.
- Requests during CLEAR (write_enb or read_enb high):
  - Ignored; memory is not modified by the request.
  - req_drop=1 for that one cycle; data_valid=0.
- READY, write only (write_enb=1, read_enb=0) at edge N: mem[address] <= data_in; data_valid=0; data_out holds.
- READY, read only (read_enb=1, write_enb=0) at edge N:
  - data_out <= mem[address] and data_valid <= 1, registered on edge N.
  - The monitor samples both at edge N+1 (one-cycle latency).
- Back-to-back reads: one result per cycle, no bubbles. data_valid stays high for consecutive accepted reads.
- Read at edge N+1 of an address written at edge N returns the new data. There is no bypass path; the array is updated at edge N.
- Collision (both enables high in READY):
  - Write is performed, read is not.
  - data_valid=0, data_out holds, collision=1 for one cycle.
- No request: data_valid=0, collision=0, req_drop=0, data_out holds its last value.
- Address range: the full ADDR_WIDTH range is valid with no wrap logic needed; an X/Z address is not a supported stimulus.
- Flag timing: all flags are registered one-cycle pulses and never stick.

Test Plan:
- Reset then idle 32 cycles: busy=1 through edge 31 and busy=0 after edge 32. Reads of addresses 0..31 return 8'h00 with data_valid=1 each, one cycle after each request.
- Write 8'hA5 to address 5, then read address 5 on the next cycle: data_out=8'hA5, data_valid=1 one cycle later. Read address 6 returns 8'h00.
- Write 8'h3C to address 31, then read address 31 and address 0 back to back: data_out=8'h3C then 8'h00, with data_valid high for two consecutive cycles.
- write_enb=read_enb=1, address 10, data_in=8'h77: collision=1 for one cycle, data_valid=0, data_out unchanged. A later read of address 10 returns 8'h77.
- Write to address 3 at edge 5 during CLEAR: req_drop=1 for one cycle. After busy falls, a read of address 3 returns 8'h00.
- Write 8'hFF to address 2, then assert reset mid-sequence: outputs return to 0 and busy=1 immediately. After release and 32 clear cycles, reading address 2 returns 8'h00.
